laser_safety_sequencer: RTL and testbench
=========================================

# laser_safety_sequencer

Controls laser enable for the safety FPGA, using the pulse-timing and ADC fail flags from the limit checker. It arms the laser only on a host request followed by a hold-off period. On the first unmasked fault it drops the enable and latches the fault. It also sequences the limit checker's `clear_fail` strobe and re-checks the flags before it returns to idle.

## Interface
- `ARM_HOLDOFF`, 16: cycles spent in HOLDOFF before ARMED; legal range 1..65535.
- `CLEAR_CYCLES`, 4: cycles `clear_fail` is held high during CLEARING; legal range 1..65535.
- `clk` in 1: system clock; everything runs on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `arm_req` in 1: host arm level; only its rising edge arms.
- `clear_req` in 1: host fault-clear request, one-cycle pulse.
- `fail_in` in 9: fail flags from the limit checker. Bit 0 pulse_lower, 1 pulse_upper, 2 rate_lower, 3 rate_upper, 4 current, 5 adc_pw_lower, 6 adc_pw_upper, 7 adc_rate_lower, 8 adc_rate_upper.
- `fail_mask` in 9: 1 means the matching `fail_in` bit is ignored.
- `laser_pulse_in` in 1: raw laser pulse request.
- `laser_pulse_out` out 1: `laser_pulse_in & laser_enable`, combinational, zero latency.
- `laser_enable` out 1: registered; 1 only in ARMED.
- `clear_fail` out 1: registered clear strobe to the limit checker.
- `fault_latched` out 1: registered; 1 in FAULT and CLEARING.
- `fault_code` out 9: the active fail bits captured on entry to FAULT.
- `fault_count` out 16: number of FAULT entries, saturating.
- `state` out 3: current state encoding.

## Operation
- `act_fail = |(fail_in & ~fail_mask)`, evaluated combinationally every cycle.
- `arm_edge = arm_req & ~arm_req_d`, where `arm_req_d` is `arm_req` registered.
- States and encodings: DISABLED=0, HOLDOFF=1, ARMED=2, FAULT=3, CLEARING=4. Encodings 5..7 are illegal and go to FAULT with `fault_code`=0.
- DISABLED:
  - `arm_edge` with `act_fail` -> FAULT.
  - `arm_edge` without `act_fail` -> HOLDOFF, counter loaded with `ARM_HOLDOFF`-1.
  - Fails are otherwise ignored.
- HOLDOFF, in priority order:
  - `act_fail` -> FAULT.
  - `arm_req`=0 -> DISABLED.
  - counter=0 -> ARMED.
  - otherwise decrement the counter.
- ARMED:
  - `act_fail` -> FAULT; fail has priority over `arm_req` dropping.
  - `arm_req`=0 -> DISABLED.
- FAULT:
  - `clear_req` -> CLEARING, counter loaded with `CLEAR_CYCLES`-1.
  - `arm_req` is ignored.
- CLEARING:
  - `clear_fail`=1 for `CLEAR_CYCLES` cycles, then one settle cycle with `clear_fail`=0.
  - In the settle cycle, `act_fail` -> FAULT (re-entry); otherwise -> DISABLED.
  - `clear_req` is ignored during CLEARING.
- Every entry into FAULT:
  - `fault_code` <= `fail_in & ~fail_mask` as seen in the entering cycle.
  - `fault_count` increments, saturating at 0xFFFF.
- On CLEARING -> DISABLED, `fault_code` is cleared to 0. `fault_count` is cleared only by reset.
- After a clear, re-arming needs a new `arm_req` rising edge; a level held high since before the fault does not re-arm.
- `fail_mask` changes take effect immediately in `act_fail`.

## Timing
- Reset values:
  - `state`=DISABLED.
  - `laser_enable`, `clear_fail`, `fault_latched`=0.
  - `fault_code`=0, `fault_count`=0, `arm_req_d`=0.
  - Reset takes effect asynchronously at any point, including mid-HOLDOFF or mid-CLEARING.
- `arm_req` rising at cycle N: HOLDOFF from N+1, `laser_enable`=1 at N+1+`ARM_HOLDOFF`.
- `act_fail` at cycle N while in ARMED: `state`=FAULT, `laser_enable`=0 and `fault_latched`=1 at N+1. The maximum unguarded pulse is one clock.
- `clear_req` at cycle N while in FAULT:
  - `clear_fail`=1 for cycles N+1..N+`CLEAR_CYCLES`.
  - Settle cycle is N+`CLEAR_CYCLES`+1.
  - DISABLED (or FAULT) from N+`CLEAR_CYCLES`+2.
- `clear_req` and `act_fail` in the same FAULT cycle: the clear proceeds; the fail is re-checked in the settle cycle.
- `arm_req` fall and `act_fail` in the same ARMED cycle: go to FAULT.
- `ARM_HOLDOFF`=1: HOLDOFF lasts exactly one cycle.

## Test plan
- **Arm:** reset, `fail_mask`=0, pulse `arm_req` 0->1 at cycle 10 with `ARM_HOLDOFF`=16. Expect `state`=1 at cycle 11 and `laser_enable`=1 at cycle 27. `laser_pulse_out` follows `laser_pulse_in` from cycle 27.
- **Fault in ARMED:** assert `fail_in`=0x010 for one cycle. Expect next cycle `state`=3, `laser_enable`=0, `fault_code`=0x010, `fault_count`=1, and `laser_pulse_out`=0 even with `laser_pulse_in` held high.
- **Clear:** in FAULT, pulse `clear_req` with `CLEAR_CYCLES`=4 and fails low. Expect `clear_fail` high for exactly 4 cycles, then `state`=0 and `fault_code`=0. With `arm_req` still high, expect no re-arm until `arm_req` is toggled 0->1.
- **Stuck fail:** hold `fail_in`=0x100 through CLEARING. Expect re-entry to FAULT after the settle cycle, `fault_count`=2, `fault_code`=0x100.
- **Mask:** `fail_mask`=0x1FF, toggle all `fail_in` bits while ARMED. Expect `laser_enable` to stay 1. Then set `fail_mask`=0 with `fail_in`=0x001. Expect FAULT the next cycle.
- **Reset and arm abort:** assert `rstn`=0 mid-HOLDOFF. Expect all outputs 0 immediately and `state`=0. In a second run, drop `arm_req` during HOLDOFF. Expect DISABLED the next cycle with `laser_enable` never asserted.

Source files
------------

// File: rtl/laser_safety_sequencer_if.sv
// laser_safety_sequencer_if
// Groups the host/limit-checker signals of the laser safety sequencer.
//   arm_req, clear_req         : host arm level and one-cycle clear pulse
//   fail_in, fail_mask         : limit-checker fail flags and ignore mask
//   laser_pulse_in/out         : raw pulse request and gated pulse
//   laser_enable, clear_fail   : registered enable and clear strobe
//   fault_latched, fault_code  : fault status and captured fail bits
//   fault_count, state         : saturating fault counter and FSM state (debug)
// Signalling: there is no valid/ready handshake on this block. arm_req is a
// level whose rising edge arms, clear_req is sampled as a single-cycle pulse,
// and every output is a level that is valid every cycle.
interface laser_safety_sequencer_if;
    logic        arm_req;
    logic        clear_req;
    logic [8:0]  fail_in;
    logic [8:0]  fail_mask;
    logic        laser_pulse_in;
    logic        laser_pulse_out;
    logic        laser_enable;
    logic        clear_fail;
    logic        fault_latched;
    logic [8:0]  fault_code;
    logic [15:0] fault_count;
    logic [2:0]  state;

    modport master (
        output arm_req, clear_req, fail_in, fail_mask, laser_pulse_in,
        input  laser_pulse_out, laser_enable, clear_fail, fault_latched,
               fault_code, fault_count, state
    );

    modport slave (
        input  arm_req, clear_req, fail_in, fail_mask, laser_pulse_in,
        output laser_pulse_out, laser_enable, clear_fail, fault_latched,
               fault_code, fault_count, state
    );
endinterface

// File: rtl/laser_safety_sequencer.sv
// laser_safety_sequencer
// Arms the laser after a host arm edge plus a hold-off, drops the enable on
// the first unmasked fail flag, latches the fault, and sequences the limit
// checker's clear strobe with a final re-check of the flags.
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : laser_safety_sequencer_if.slave (all host / checker signals)
module laser_safety_sequencer #(
    parameter int unsigned ARM_HOLDOFF  = 16,
    parameter int unsigned CLEAR_CYCLES = 4
) (
    input logic                      clk,
    input logic                      rstn,
    laser_safety_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_DISABLED = 3'd0,
        S_HOLDOFF  = 3'd1,
        S_ARMED    = 3'd2,
        S_FAULT    = 3'd3,
        S_CLEARING = 3'd4
    } state_t;

    localparam logic [15:0] HOLDOFF_LOAD = 16'(ARM_HOLDOFF - 1);
    localparam logic [15:0] CLEAR_LOAD   = 16'(CLEAR_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        settle_q, settle_d;   // CLEARING sub-phase: 1 = settle cycle
    logic        arm_req_d;
    logic        laser_enable_q;
    logic        clear_fail_q;
    logic        fault_latched_q;
    logic [8:0]  fault_code_q;
    logic [15:0] fault_count_q;

    logic [8:0]  act_vec;
    logic        act_fail;
    logic        arm_edge;
    logic        enter_fault;
    logic        illegal;

    assign act_vec  = bus.fail_in & ~bus.fail_mask;
    assign act_fail = |act_vec;
    assign arm_edge = bus.arm_req & ~arm_req_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        illegal  = 1'b0;
        case (state_q)
            S_DISABLED: begin
                if (arm_edge) begin
                    if (act_fail) begin
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = HOLDOFF_LOAD;
                    end
                end
            end
            S_HOLDOFF: begin
                if (act_fail)            state_d = S_FAULT;
                else if (!bus.arm_req)   state_d = S_DISABLED;
                else if (cnt_q == 16'd0) state_d = S_ARMED;
                else                     cnt_d   = cnt_q - 16'd1;
            end
            S_ARMED: begin
                // A fail wins over arm_req dropping in the same cycle.
                if (act_fail)          state_d = S_FAULT;
                else if (!bus.arm_req) state_d = S_DISABLED;
            end
            S_FAULT: begin
                if (bus.clear_req) begin
                    state_d  = S_CLEARING;
                    cnt_d    = CLEAR_LOAD;
                    settle_d = 1'b0;
                end
            end
            S_CLEARING: begin
                if (!settle_q) begin
                    if (cnt_q == 16'd0) settle_d = 1'b1;
                    else                cnt_d    = cnt_q - 16'd1;
                end else begin
                    // Settle cycle: flags must be clean to leave the fault path.
                    settle_d = 1'b0;
                    state_d  = act_fail ? S_FAULT : S_DISABLED;
                end
            end
            default: begin
                state_d = S_FAULT;
                illegal = 1'b1;
            end
        endcase
    end

    assign enter_fault = (state_d == S_FAULT) && (state_q != S_FAULT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= S_DISABLED;
            cnt_q           <= 16'd0;
            settle_q        <= 1'b0;
            arm_req_d       <= 1'b0;
            laser_enable_q  <= 1'b0;
            clear_fail_q    <= 1'b0;
            fault_latched_q <= 1'b0;
            fault_code_q    <= 9'd0;
            fault_count_q   <= 16'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            settle_q        <= settle_d;
            arm_req_d       <= bus.arm_req;
            // Outputs are decoded from the next state so they line up with state.
            laser_enable_q  <= (state_d == S_ARMED);
            clear_fail_q    <= (state_d == S_CLEARING) && !settle_d;
            fault_latched_q <= (state_d == S_FAULT) || (state_d == S_CLEARING);
            if (enter_fault) begin
                fault_code_q <= illegal ? 9'd0 : act_vec;
                if (fault_count_q != 16'hFFFF) fault_count_q <= fault_count_q + 16'd1;
            end else if (state_q == S_CLEARING && state_d == S_DISABLED) begin
                fault_code_q <= 9'd0;
            end
        end
    end

    assign bus.laser_pulse_out = bus.laser_pulse_in & laser_enable_q;
    assign bus.laser_enable    = laser_enable_q;
    assign bus.clear_fail      = clear_fail_q;
    assign bus.fault_latched   = fault_latched_q;
    assign bus.fault_code      = fault_code_q;
    assign bus.fault_count     = fault_count_q;
    assign bus.state           = state_q;
endmodule

// File: tb/tb_laser_safety_sequencer.sv
// tb_laser_safety_sequencer
// Directed bench for laser_safety_sequencer: one instance with ARM_HOLDOFF=16,
// CLEAR_CYCLES=4 and one with both set to 1 for the boundary case.
module tb_laser_safety_sequencer;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    laser_safety_sequencer_if bus ();
    laser_safety_sequencer_if bus1 ();

    laser_safety_sequencer #(.ARM_HOLDOFF(16), .CLEAR_CYCLES(4)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    laser_safety_sequencer #(.ARM_HOLDOFF(1), .CLEAR_CYCLES(1)) u_dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic exp_chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
        push_exp(v);
        check(tag, obs);
    endtask

    initial begin
        bus.arm_req = 0; bus.clear_req = 0; bus.fail_in = 0; bus.fail_mask = 0; bus.laser_pulse_in = 0;
        bus1.arm_req = 0; bus1.clear_req = 0; bus1.fail_in = 0; bus1.fail_mask = 0; bus1.laser_pulse_in = 0;
        tick(3);
        rstn = 1'b1;
        tick(2);

        // Reset state
        exp_chk("rst_state", 32'(bus.state), 0);
        exp_chk("rst_enable", 32'(bus.laser_enable), 0);
        exp_chk("rst_clear_fail", 32'(bus.clear_fail), 0);
        exp_chk("rst_latched", 32'(bus.fault_latched), 0);
        exp_chk("rst_code", 32'(bus.fault_code), 0);
        exp_chk("rst_count", 32'(bus.fault_count), 0);
        bus.laser_pulse_in = 1; #1;
        exp_chk("rst_pulse_out", 32'(bus.laser_pulse_out), 0);
        bus.laser_pulse_in = 0;

        // Fails ignored in DISABLED without an arm edge
        bus.fail_in = 9'h1FF;
        tick(2);
        exp_chk("dis_ignore_state", 32'(bus.state), 0);
        exp_chk("dis_ignore_count", 32'(bus.fault_count), 0);
        bus.fail_in = 0;

        // Arm: HOLDOFF next cycle, ARMED 1+16 cycles after the edge
        bus.arm_req = 1;
        tick();
        exp_chk("arm_holdoff", 32'(bus.state), 1);
        exp_chk("arm_holdoff_en", 32'(bus.laser_enable), 0);
        tick(15);
        exp_chk("arm_last_holdoff", 32'(bus.state), 1);
        exp_chk("arm_last_holdoff_en", 32'(bus.laser_enable), 0);
        tick();
        exp_chk("arm_armed", 32'(bus.state), 2);
        exp_chk("arm_enable", 32'(bus.laser_enable), 1);
        bus.laser_pulse_in = 1; #1;
        exp_chk("pulse_pass_hi", 32'(bus.laser_pulse_out), 1);
        bus.laser_pulse_in = 0; #1;
        exp_chk("pulse_pass_lo", 32'(bus.laser_pulse_out), 0);
        bus.laser_pulse_in = 1;

        // Fault in ARMED
        bus.fail_in = 9'h010;
        tick();
        bus.fail_in = 0;
        exp_chk("flt_state", 32'(bus.state), 3);
        exp_chk("flt_enable", 32'(bus.laser_enable), 0);
        exp_chk("flt_latched", 32'(bus.fault_latched), 1);
        exp_chk("flt_code", 32'(bus.fault_code), 32'h010);
        exp_chk("flt_count", 32'(bus.fault_count), 1);
        exp_chk("flt_pulse_out", 32'(bus.laser_pulse_out), 0);

        // arm_req toggling is ignored in FAULT
        bus.arm_req = 0;
        tick();
        bus.arm_req = 1;
        tick();
        exp_chk("flt_arm_ignored", 32'(bus.state), 3);

        // Clear: clear_fail for 4 cycles, settle cycle, then DISABLED
        push_exp(1); push_exp(1); push_exp(1); push_exp(1); push_exp(0);
        bus.clear_req = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.clear_req = 0;
            check("clr_strobe", 32'(bus.clear_fail));
        end
        exp_chk("clr_settle_state", 32'(bus.state), 4);
        exp_chk("clr_settle_latched", 32'(bus.fault_latched), 1);
        tick();
        exp_chk("clr_done_state", 32'(bus.state), 0);
        exp_chk("clr_done_code", 32'(bus.fault_code), 0);
        exp_chk("clr_done_latched", 32'(bus.fault_latched), 0);
        exp_chk("clr_done_count", 32'(bus.fault_count), 1);

        // Held arm_req does not re-arm; a fresh edge does
        tick(20);
        exp_chk("no_rearm_state", 32'(bus.state), 0);
        exp_chk("no_rearm_en", 32'(bus.laser_enable), 0);
        bus.arm_req = 0;
        tick();
        bus.arm_req = 1;
        tick();
        exp_chk("rearm_holdoff", 32'(bus.state), 1);

        // Arm abort in HOLDOFF
        tick(3);
        bus.arm_req = 0;
        tick();
        exp_chk("abort_state", 32'(bus.state), 0);
        exp_chk("abort_en", 32'(bus.laser_enable), 0);

        // Arm edge with an active fail goes straight to FAULT; stuck fail re-enters
        bus.fail_in = 9'h100;
        bus.arm_req = 1;
        tick();
        exp_chk("stuck_entry_state", 32'(bus.state), 3);
        exp_chk("stuck_entry_code", 32'(bus.fault_code), 32'h100);
        exp_chk("stuck_entry_count", 32'(bus.fault_count), 2);
        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        exp_chk("stuck_clearing", 32'(bus.state), 4);
        tick(4);
        exp_chk("stuck_settle_state", 32'(bus.state), 4);
        exp_chk("stuck_settle_cf", 32'(bus.clear_fail), 0);
        tick();
        exp_chk("stuck_reentry_state", 32'(bus.state), 3);
        exp_chk("stuck_reentry_count", 32'(bus.fault_count), 3);
        exp_chk("stuck_reentry_code", 32'(bus.fault_code), 32'h100);
        exp_chk("stuck_reentry_latched", 32'(bus.fault_latched), 1);

        bus.fail_in = 0;
        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        tick(5);
        exp_chk("recover_state", 32'(bus.state), 0);

        // Mask: all fails masked while ARMED, then unmask one
        bus.arm_req = 0;
        tick();
        bus.fail_mask = 9'h1FF;
        bus.arm_req = 1;
        tick(17);
        exp_chk("mask_armed", 32'(bus.state), 2);
        for (int i = 0; i < 8; i++) begin
            bus.fail_in = (i == 0) ? 9'h1FF : 9'($urandom_range(0, 511));
            tick();
            exp_chk("mask_hold_en", 32'(bus.laser_enable), 1);
        end
        bus.fail_mask = 0;
        bus.fail_in = 9'h001;
        tick();
        bus.fail_in = 0;
        exp_chk("unmask_state", 32'(bus.state), 3);
        exp_chk("unmask_code", 32'(bus.fault_code), 32'h001);
        exp_chk("unmask_count", 32'(bus.fault_count), 4);

        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        tick(5);
        exp_chk("recover2_state", 32'(bus.state), 0);

        // arm_req fall and fail in the same ARMED cycle -> FAULT
        bus.arm_req = 0;
        tick();
        bus.arm_req = 1;
        tick(17);
        exp_chk("prio_armed", 32'(bus.state), 2);
        bus.arm_req = 0;
        bus.fail_in = 9'h008;
        tick();
        bus.fail_in = 0;
        exp_chk("prio_state", 32'(bus.state), 3);
        exp_chk("prio_code", 32'(bus.fault_code), 32'h008);
        exp_chk("prio_count", 32'(bus.fault_count), 5);

        bus.clear_req = 1;
        tick();
        bus.clear_req = 0;
        tick(5);
        exp_chk("recover3_state", 32'(bus.state), 0);

        // Asynchronous reset mid-HOLDOFF
        bus.arm_req = 1;
        tick(5);
        exp_chk("pre_rst_holdoff", 32'(bus.state), 1);
        #2;
        rstn = 1'b0;
        #1;
        exp_chk("async_rst_state", 32'(bus.state), 0);
        exp_chk("async_rst_en", 32'(bus.laser_enable), 0);
        exp_chk("async_rst_cf", 32'(bus.clear_fail), 0);
        exp_chk("async_rst_latched", 32'(bus.fault_latched), 0);
        exp_chk("async_rst_code", 32'(bus.fault_code), 0);
        exp_chk("async_rst_count", 32'(bus.fault_count), 0);
        tick(2);
        bus.arm_req = 0;
        rstn = 1'b1;
        tick();

        // Boundary instance: ARM_HOLDOFF=1, CLEAR_CYCLES=1
        bus1.arm_req = 1;
        tick();
        exp_chk("h1_holdoff", 32'(bus1.state), 1);
        tick();
        exp_chk("h1_armed", 32'(bus1.state), 2);
        exp_chk("h1_enable", 32'(bus1.laser_enable), 1);
        bus1.fail_in = 9'h020;
        tick();
        bus1.fail_in = 0;
        exp_chk("h1_fault", 32'(bus1.state), 3);
        exp_chk("h1_code", 32'(bus1.fault_code), 32'h020);
        exp_chk("h1_count", 32'(bus1.fault_count), 1);
        bus1.clear_req = 1;
        tick();
        bus1.clear_req = 0;
        exp_chk("h1_clear_cf", 32'(bus1.clear_fail), 1);
        tick();
        exp_chk("h1_settle_cf", 32'(bus1.clear_fail), 0);
        exp_chk("h1_settle_state", 32'(bus1.state), 4);
        tick();
        exp_chk("h1_done_state", 32'(bus1.state), 0);
        exp_chk("h1_done_code", 32'(bus1.fault_code), 0);

        // Every expected value pushed must have been consumed
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
